// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads a combinational instruction memory and
// presents each fetched instruction through a registered valid/ready slot.
module instr_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [XLEN-1:0]  imem_instr,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic             fault,
    output logic [XLEN-1:0]  fault_addr,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic {StRun, StFault} state_e;

    state_e           r_state, w_state_next;
    logic [XLEN-1:0]  r_pc, w_pc_next;
    logic             r_out_valid, w_out_valid_next;
    logic [XLEN-1:0]  r_out_instr, w_out_instr_next;
    logic [XLEN-1:0]  r_out_pc, w_out_pc_next;
    logic             r_fault, w_fault_next;
    logic [XLEN-1:0]  r_fault_addr, w_fault_addr_next;
    logic [CNT_W-1:0] r_fetch_count, w_fetch_count_next;
    logic             w_fire;

    // A slot can be refilled when empty or when its current content leaves this cycle.
    assign w_fire = en & (~r_out_valid | out_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StRun;
            r_pc          <= RESET_PC;
            r_out_valid   <= 1'b0;
            r_out_instr   <= '0;
            r_out_pc      <= '0;
            r_fault       <= 1'b0;
            r_fault_addr  <= '0;
            r_fetch_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_out_valid   <= w_out_valid_next;
            r_out_instr   <= w_out_instr_next;
            r_out_pc      <= w_out_pc_next;
            r_fault       <= w_fault_next;
            r_fault_addr  <= w_fault_addr_next;
            r_fetch_count <= w_fetch_count_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_out_valid_next   = r_out_valid;
        w_out_instr_next   = r_out_instr;
        w_out_pc_next      = r_out_pc;
        w_fault_next       = r_fault;
        w_fault_addr_next  = r_fault_addr;
        w_fetch_count_next = r_fetch_count;

        unique case (r_state)
            StRun: begin
                if (redirect_valid) begin
                    // Redirect flushes the slot even if decode would have taken it.
                    w_out_valid_next = 1'b0;
                    if (redirect_target[1:0] == 2'b00) begin
                        w_pc_next = redirect_target;
                    end else begin
                        w_fault_next      = 1'b1;
                        w_fault_addr_next = redirect_target;
                        w_state_next      = StFault;
                    end
                end else if (w_fire) begin
                    w_out_instr_next = imem_instr;
                    w_out_pc_next    = r_pc;
                    w_out_valid_next = 1'b1;
                    w_pc_next        = r_pc + XLEN'(4);
                    if (r_fetch_count != '1) begin
                        w_fetch_count_next = r_fetch_count + CNT_W'(1);
                    end
                end else if (r_out_valid && out_ready) begin
                    w_out_valid_next = 1'b0;
                end
            end
            StFault: begin
                w_out_valid_next = 1'b0;
            end
            default: begin
                w_state_next = StFault;
            end
        endcase
    end

    assign imem_addr   = r_pc;
    assign out_valid   = r_out_valid;
    assign out_instr   = r_out_instr;
    assign out_pc      = r_out_pc;
    assign fault       = r_fault;
    assign fault_addr  = r_fault_addr;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random traffic
// compared against a behavioural model of the fetch slot.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_ready;

    logic [31:0] d_addr, d_imem, d_instr, d_opc, d_faddr;
    logic        d_valid, d_fault;
    logic [15:0] d_cnt;

    logic [31:0] w_addr, w_imem, w_instr, w_opc, w_faddr;
    logic        w_valid, w_fault;
    logic [2:0]  w_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_opc, m_faddr;
    logic        m_valid, m_fault;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    assign d_imem = 32'hA000_0000 | d_addr;
    assign w_imem = 32'hA000_0000 | w_addr;

    instr_fetch_unit u_dut (
        .clk             (clk),
        .reset           (reset),
        .en              (en),
        .imem_addr       (d_addr),
        .imem_instr      (d_imem),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (d_valid),
        .out_ready       (out_ready),
        .out_instr       (d_instr),
        .out_pc          (d_opc),
        .fault           (d_fault),
        .fault_addr      (d_faddr),
        .fetch_count     (d_cnt)
    );

    // Second instance: wrap-around start PC and a tiny counter to reach saturation.
    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'hFFFF_FFFC),
        .CNT_W    (3)
    ) u_dut_wrap (
        .clk             (clk),
        .reset           (reset),
        .en              (en),
        .imem_addr       (w_addr),
        .imem_instr      (w_imem),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (w_valid),
        .out_ready       (out_ready),
        .out_instr       (w_instr),
        .out_pc          (w_opc),
        .fault           (w_fault),
        .fault_addr      (w_faddr),
        .fetch_count     (w_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_opc   = 32'h0;
        m_fault = 1'b0;
        m_faddr = 32'h0;
        m_cnt   = 16'h0;
    endtask

    // One clock edge of the fetch rules, applied to the model in priority order.
    task automatic model_edge();
        if (m_fault) begin
            m_valid = 1'b0;
        end else if (redirect_valid) begin
            m_valid = 1'b0;
            if (redirect_target % 4 == 0) begin
                m_pc = redirect_target;
            end else begin
                m_fault = 1'b1;
                m_faddr = redirect_target;
            end
        end else if (en && (!m_valid || out_ready)) begin
            m_instr = 32'hA000_0000 | m_pc;
            m_opc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".imem_addr"}, d_addr, m_pc);
        chk({tag, ".out_valid"}, {31'b0, d_valid}, {31'b0, m_valid});
        chk({tag, ".out_instr"}, d_instr, m_instr);
        chk({tag, ".out_pc"}, d_opc, m_opc);
        chk({tag, ".fault"}, {31'b0, d_fault}, {31'b0, m_fault});
        chk({tag, ".fault_addr"}, d_faddr, m_faddr);
        chk({tag, ".fetch_count"}, {16'b0, d_cnt}, {16'b0, m_cnt});
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge; pulses reset well clear of both clock edges.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk_all(tag);
        reset = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        en              = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        out_ready       = 1'b0;
        model_reset();
        #12;
        chk_all("reset_init");
        chk("reset_init.wrap_addr", w_addr, 32'hFFFF_FFFC);
        reset = 1'b0;

        // T1: streaming
        en        = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_all("t1");
            chk("t1.out_pc_seq", d_opc, 32'(4 * i));
            chk("t1.out_instr_seq", d_instr, 32'hA000_0000 | 32'(4 * i));
        end
        chk("t1.count", {16'b0, d_cnt}, 32'd4);

        // T2: backpressure
        do_reset("t2_reset");
        step();
        step();
        chk_all("t2_fill");
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("t2_hold");
            chk("t2_hold.out_pc", d_opc, 32'h4);
            chk("t2_hold.imem_addr", d_addr, 32'h8);
        end
        out_ready = 1'b1;
        step();
        chk_all("t2_release");
        chk("t2_release.out_pc", d_opc, 32'h8);

        // T3: redirect while slot is valid
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        step();
        chk_all("t3_flush");
        chk("t3_flush.out_valid", {31'b0, d_valid}, 32'd0);
        redirect_valid = 1'b0;
        step();
        chk_all("t3_target");
        chk("t3_target.out_pc", d_opc, 32'h40);
        chk("t3_target.out_instr", d_instr, 32'hA000_0040);

        // T4: misaligned redirect, then an ignored aligned one
        redirect_valid  = 1'b1;
        redirect_target = 32'h42;
        step();
        chk_all("t4_fault");
        chk("t4_fault.fault", {31'b0, d_fault}, 32'd1);
        chk("t4_fault.fault_addr", d_faddr, 32'h42);
        redirect_target = 32'h0;
        step();
        redirect_valid = 1'b0;
        chk_all("t4_ignored");
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("t4_halted");
            chk("t4_halted.out_valid", {31'b0, d_valid}, 32'd0);
        end

        // T6 (fault case): async reset clears sticky fault before the next edge
        do_reset("t6_fault_reset");

        // T5: wrap-around and counter saturation on the second instance
        for (int i = 1; i <= 10; i++) begin
            step();
            chk_all("t5_main");
            if (i == 1) begin
                chk("t5.first_pc", w_opc, 32'hFFFF_FFFC);
                chk("t5.first_instr", w_instr, 32'hFFFF_FFFC);
            end
            if (i == 2) begin
                chk("t5.wrap_pc", w_opc, 32'h0);
                chk("t5.wrap_instr", w_instr, 32'hA000_0000);
                chk("t5.wrap_addr", w_addr, 32'h4);
            end
            chk("t5.valid", {31'b0, w_valid}, 32'd1);
            chk("t5.count", {29'b0, w_cnt}, (i < 7) ? 32'(i) : 32'd7);
        end
        chk("t5.fault", {31'b0, w_fault}, 32'd0);
        chk("t5.fault_addr", w_faddr, 32'h0);

        // T6: reset mid-handshake
        chk("t6_pre.out_valid", {31'b0, d_valid}, 32'd1);
        do_reset("t6_midop");
        chk("t6_midop.imem_addr", d_addr, 32'h0);
        chk("t6_midop.count", {16'b0, d_cnt}, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            en             = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_target = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0)
                redirect_target = redirect_target | 32'($urandom_range(1, 3));
            step();
            chk_all("rand");
            if ($urandom_range(0, 39) == 0 || (m_fault && $urandom_range(0, 7) == 0))
                do_reset("rand_reset");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
